decode_stage: RTL

Single-entry, registered decode/operand stage directly upstream of the `alu`. It accepts one 16-bit instruction per cycle from fetch and splits it into `oper`, `func`, `cond` and register addresses. It reads both operands from the register file and extends immediates, then presents registered `dst`/`src`/`oper`/`func`/`cond`/`sign_ext_imm` to the ALU. Stalls come from downstream back-pressure and from a read-after-write hazard against the instruction in execute.

---
 rtl/cpu_pkg.sv | 66 ++++++
 rtl/instr_fields.sv | 73 +++++++
 rtl/decode_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, function-code and condition-code encodings for the
// 16-bit CPU pipeline, plus a helper that classifies immediate extension.
//   oper codes : instr[15:12]
//   func codes : instr[7:4] (register form only)
//   cond codes : instr[11:8] (Bcond / Jcond only)
package cpu_pkg;

  localparam int unsigned INSTR_W = 16;

  // oper codes
  localparam logic [3:0] OP_REG     = 4'b0000;
  localparam logic [3:0] OP_ANDI    = 4'b0001;
  localparam logic [3:0] OP_ORI     = 4'b0010;
  localparam logic [3:0] OP_XORI    = 4'b0011;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_ADD     = 4'b0101;
  localparam logic [3:0] OP_ADDU    = 4'b0110;
  localparam logic [3:0] OP_ADDC    = 4'b0111;
  localparam logic [3:0] OP_SHIFT   = 4'b1000;
  localparam logic [3:0] OP_SUB     = 4'b1001;
  localparam logic [3:0] OP_SUBC    = 4'b1010;
  localparam logic [3:0] OP_CMP     = 4'b1011;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_MOV     = 4'b1101;
  localparam logic [3:0] OP_MUL     = 4'b1110;
  localparam logic [3:0] OP_LUI     = 4'b1111;

  // func codes (share the oper encoding for the ALU operations)
  localparam logic [3:0] FN_NOP     = 4'b0000;
  localparam logic [3:0] FN_ADD     = 4'b0101;
  localparam logic [3:0] FN_SPC_WB  = 4'b1000;  // the only SPECIAL func that writes back
  localparam logic [3:0] FN_CMP     = 4'b1011;
  localparam logic [3:0] FN_JCOND   = 4'b1100;
  localparam logic [3:0] FN_MOV     = 4'b1101;

  // condition codes
  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4;
  localparam logic [3:0] CC_LS = 4'd5;
  localparam logic [3:0] CC_GT = 4'd6;
  localparam logic [3:0] CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8;
  localparam logic [3:0] CC_FC = 4'd9;
  localparam logic [3:0] CC_LO = 4'd10;
  localparam logic [3:0] CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12;
  localparam logic [3:0] CC_GE = 4'd13;
  localparam logic [3:0] CC_UC = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  // Immediate-form opcodes whose imm8 is sign-extended; every other
  // immediate opcode zero-extends.
  function automatic logic oper_sign_extends(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_MUL, OP_BCOND: r = 1'b1;
      default:                                                    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_fields.sv
// instr_fields: purely combinational split of one instruction word into the
// ALU-facing fields, operand selection and immediate extension.
//   instr          : instruction word
//   pc_in          : address of instr (operand for branches)
//   rdata_a/b      : register file data for instr[11:8] / instr[3:0]
//   oper/func/cond : ALU controls (func and cond zeroed where not meaningful)
//   dst/src        : ALU operands
//   sign_ext_imm   : immediate was sign-extended
//   wr_en/wr_addr  : writeback request
//   uses_a/uses_b  : which register operands the instruction really reads
module instr_fields
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic [WIDTH-1:0]   rdata_a,
  input  logic [WIDTH-1:0]   rdata_b,
  output logic [3:0]         oper,
  output logic [3:0]         func,
  output logic [3:0]         cond,
  output logic [WIDTH-1:0]   dst,
  output logic [WIDTH-1:0]   src,
  output logic               sign_ext_imm,
  output logic               wr_en,
  output logic [3:0]         wr_addr,
  output logic               uses_a,
  output logic               uses_b
);

  logic [3:0]       op;
  logic [3:0]       fn;
  logic [7:0]       imm8;
  logic             reg_form;
  logic             is_bcond;
  logic             is_jcond;
  logic             is_branch;
  logic             is_mov;
  logic             is_cmp;
  logic             sext;
  logic [WIDTH-1:0] imm_ext;

  always_comb begin
    op        = instr[15:12];
    fn        = instr[7:4];
    imm8      = instr[7:0];
    reg_form  = (op == OP_REG) || (op == OP_SPECIAL) || (op == OP_SHIFT);
    is_bcond  = (op == OP_BCOND);
    is_jcond  = (op == OP_SPECIAL) && (fn == FN_JCOND);
    is_branch = is_bcond || is_jcond;
    is_mov    = (op == OP_MOV) || ((op == OP_REG) && (fn == FN_MOV));
    is_cmp    = (op == OP_CMP) || ((op == OP_REG) && (fn == FN_CMP));
    sext      = oper_sign_extends(op);
    imm_ext   = sext ? {{(WIDTH-8){imm8[7]}}, imm8} : {{(WIDTH-8){1'b0}}, imm8};

    oper         = op;
    func         = reg_form ? fn : '0;
    cond         = is_branch ? instr[11:8] : '0;
    dst          = is_branch ? pc_in : rdata_a;
    src          = reg_form ? rdata_b : imm_ext;
    sign_ext_imm = !reg_form && sext;

    wr_en = !(is_cmp || is_branch ||
              ((op == OP_REG) && (fn == FN_NOP)) ||
              ((op == OP_SPECIAL) && (fn != FN_SPC_WB)));
    wr_addr = instr[11:8];

    uses_a = !(is_branch || is_mov);
    uses_b = reg_form;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: single-entry registered decode/operand stage feeding the ALU.
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_valid/in_ready       : fetch-side handshake
//   instr, pc_in            : instruction and its address
//   rf_raddr_a/b, rf_rdata_a/b : combinational register file read port
//   ex_wr_en, ex_wr_addr    : pending write of the instruction in execute
//   flush                   : discard held and incoming instruction
//   out_valid/out_ready     : execute-side handshake
//   dst, src, oper, func, cond, sign_ext_imm, wr_en, wr_addr : registered outputs
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned RADDR = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        instr,
  input  logic [WIDTH-1:0]   pc_in,
  output logic [RADDR-1:0]   rf_raddr_a,
  output logic [RADDR-1:0]   rf_raddr_b,
  input  logic [WIDTH-1:0]   rf_rdata_a,
  input  logic [WIDTH-1:0]   rf_rdata_b,
  input  logic               ex_wr_en,
  input  logic [RADDR-1:0]   ex_wr_addr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dst,
  output logic [WIDTH-1:0]   src,
  output logic [3:0]         oper,
  output logic [3:0]         func,
  output logic [3:0]         cond,
  output logic               sign_ext_imm,
  output logic               wr_en,
  output logic [RADDR-1:0]   wr_addr
);

  logic [3:0]       f_oper;
  logic [3:0]       f_func;
  logic [3:0]       f_cond;
  logic [WIDTH-1:0] f_dst;
  logic [WIDTH-1:0] f_src;
  logic             f_sext;
  logic             f_wr_en;
  logic [3:0]       f_wr_addr;
  logic             f_uses_a;
  logic             f_uses_b;

  logic             hazard;
  logic             transfer;

  logic             out_valid_d, out_valid_q;
  logic [3:0]       oper_d, oper_q;
  logic [3:0]       func_d, func_q;
  logic [3:0]       cond_d, cond_q;
  logic [WIDTH-1:0] dst_d, dst_q;
  logic [WIDTH-1:0] src_d, src_q;
  logic             sext_d, sext_q;
  logic             wr_en_d, wr_en_q;
  logic [RADDR-1:0] wr_addr_d, wr_addr_q;

  assign rf_raddr_a = RADDR'(instr[11:8]);
  assign rf_raddr_b = RADDR'(instr[3:0]);

  instr_fields #(
    .WIDTH(WIDTH)
  ) u_fields (
    .instr        (instr),
    .pc_in        (pc_in),
    .rdata_a      (rf_rdata_a),
    .rdata_b      (rf_rdata_b),
    .oper         (f_oper),
    .func         (f_func),
    .cond         (f_cond),
    .dst          (f_dst),
    .src          (f_src),
    .sign_ext_imm (f_sext),
    .wr_en        (f_wr_en),
    .wr_addr      (f_wr_addr),
    .uses_a       (f_uses_a),
    .uses_b       (f_uses_b)
  );

  always_comb begin
    hazard   = in_valid && ex_wr_en &&
               ((f_uses_a && (ex_wr_addr == rf_raddr_a)) ||
                (f_uses_b && (ex_wr_addr == rf_raddr_b)));
    in_ready = !flush && !hazard && (!out_valid_q || out_ready);
    transfer = in_valid && in_ready;
  end

  // Flush wins over load and bubble; data registers simply hold when not loading.
  always_comb begin
    out_valid_d = out_valid_q;
    oper_d      = oper_q;
    func_d      = func_q;
    cond_d      = cond_q;
    dst_d       = dst_q;
    src_d       = src_q;
    sext_d      = sext_q;
    wr_en_d     = wr_en_q;
    wr_addr_d   = wr_addr_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d = 1'b1;
      oper_d      = f_oper;
      func_d      = f_func;
      cond_d      = f_cond;
      dst_d       = f_dst;
      src_d       = f_src;
      sext_d      = f_sext;
      wr_en_d     = f_wr_en;
      wr_addr_d   = RADDR'(f_wr_addr);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      oper_q      <= '0;
      func_q      <= '0;
      cond_q      <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      sext_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      oper_q      <= oper_d;
      func_q      <= func_d;
      cond_q      <= cond_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      sext_q      <= sext_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign oper         = oper_q;
  assign func         = func_q;
  assign cond         = cond_q;
  assign dst          = dst_q;
  assign src          = src_q;
  assign sign_ext_imm = sext_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;

endmodule
